// File: rtl/param_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : param_issue_queue_if
// Description : Dispatch, wakeup and issue signal bundle of the issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_issue_queue_if #(
    parameter int DEPTH   = 16,
    parameter int NUM_FU  = 3,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 6,
    parameter int OP_W    = 4
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                        flush;
    logic                        disp_valid;
    logic                        disp_ready;
    logic [31:0]                 disp_pc;
    logic [OP_W-1:0]             disp_op;
    logic [FU_W-1:0]             disp_fu;
    logic [TAG_W-1:0]            disp_dst;
    logic [ROB_W-1:0]            disp_rob;
    logic [DATA_W-1:0]           disp_imm;
    logic [TAG_W-1:0]            disp_src1_tag;
    logic                        disp_src1_rdy;
    logic [DATA_W-1:0]           disp_src1_data;
    logic [TAG_W-1:0]            disp_src2_tag;
    logic                        disp_src2_rdy;
    logic [DATA_W-1:0]           disp_src2_data;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]   cdb_data;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU-1:0]           iss_valid;
    logic [NUM_FU*32-1:0]        iss_pc;
    logic [NUM_FU*OP_W-1:0]      iss_op;
    logic [NUM_FU*TAG_W-1:0]     iss_dst;
    logic [NUM_FU*ROB_W-1:0]     iss_rob;
    logic [NUM_FU*DATA_W-1:0]    iss_imm;
    logic [NUM_FU*DATA_W-1:0]    iss_src1;
    logic [NUM_FU*DATA_W-1:0]    iss_src2;
    logic [OCC_W-1:0]            occupancy;

    modport master (
        output flush, disp_valid, disp_pc, disp_op, disp_fu, disp_dst, disp_rob, disp_imm,
               disp_src1_tag, disp_src1_rdy, disp_src1_data,
               disp_src2_tag, disp_src2_rdy, disp_src2_data,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  disp_ready, iss_valid, iss_pc, iss_op, iss_dst, iss_rob, iss_imm,
               iss_src1, iss_src2, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_pc, disp_op, disp_fu, disp_dst, disp_rob, disp_imm,
               disp_src1_tag, disp_src1_rdy, disp_src1_data,
               disp_src2_tag, disp_src2_rdy, disp_src2_data,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        output disp_ready, iss_valid, iss_pc, iss_op, iss_dst, iss_rob, iss_imm,
               iss_src1, iss_src2, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/param_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : param_issue_queue
// Description : Unified issue queue with CDB operand capture and oldest-first
//               select per FU. IQ_PERF_CNT_EN adds issue / full-stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module param_issue_queue #(
    parameter int DEPTH   = 16,
    parameter int NUM_FU  = 3,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 6,
    parameter int OP_W    = 4
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    param_issue_queue_if.slave  iq_if
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issued_o,
    output logic [31:0]         perf_full_cycles_o
`endif
);
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] C_DEPTH  = DEPTH[OCC_W-1:0];
    localparam logic [FU_W:0]    C_NUM_FU = NUM_FU[FU_W:0];

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  age_q      [DEPTH];
    logic [FU_W-1:0]   fu_q       [DEPTH];
    logic [31:0]       pc_q       [DEPTH];
    logic [OP_W-1:0]   op_q       [DEPTH];
    logic [TAG_W-1:0]  dst_q      [DEPTH];
    logic [ROB_W-1:0]  rob_q      [DEPTH];
    logic [DATA_W-1:0] imm_q      [DEPTH];
    logic [TAG_W-1:0]  s1_tag_q   [DEPTH];
    logic [TAG_W-1:0]  s2_tag_q   [DEPTH];
    logic [DATA_W-1:0] s1_data_q  [DEPTH];
    logic [DATA_W-1:0] s2_data_q  [DEPTH];
    logic [DEPTH-1:0]  s1_rdy_q;
    logic [DEPTH-1:0]  s2_rdy_q;
    logic [OCC_W-1:0]  occ_q;

    logic [NUM_FU-1:0] iss_valid_q;
    logic [31:0]       iss_pc_q   [NUM_FU];
    logic [OP_W-1:0]   iss_op_q   [NUM_FU];
    logic [TAG_W-1:0]  iss_dst_q  [NUM_FU];
    logic [ROB_W-1:0]  iss_rob_q  [NUM_FU];
    logic [DATA_W-1:0] iss_imm_q  [NUM_FU];
    logic [DATA_W-1:0] iss_s1_q   [NUM_FU];
    logic [DATA_W-1:0] iss_s2_q   [NUM_FU];

    logic [TAG_W-1:0]  w_cdb_tag  [NUM_CDB];
    logic [DATA_W-1:0] w_cdb_data [NUM_CDB];

    genvar gb;
    generate
        for (gb = 0; gb < NUM_CDB; gb++) begin : g_cdb
            assign w_cdb_tag[gb]  = iq_if.cdb_tag[gb*TAG_W +: TAG_W];
            assign w_cdb_data[gb] = iq_if.cdb_data[gb*DATA_W +: DATA_W];
        end
    endgenerate

    logic [DEPTH-1:0]  w_s1_hit, w_s2_hit;
    logic [DATA_W-1:0] w_s1_cdb [DEPTH];
    logic [DATA_W-1:0] w_s2_cdb [DEPTH];
    logic              w_d1_hit, w_d2_hit;
    logic [DATA_W-1:0] w_d1_cdb, w_d2_cdb;

    // Buses are scanned high to low so the lowest matching bus overwrites last.
    always_comb begin
        w_s1_hit = '0;
        w_s2_hit = '0;
        w_d1_hit = 1'b0;
        w_d2_hit = 1'b0;
        w_d1_cdb = '0;
        w_d2_cdb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_s1_cdb[i] = '0;
            w_s2_cdb[i] = '0;
        end
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (iq_if.cdb_valid[b]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (s1_tag_q[i] == w_cdb_tag[b]) begin
                        w_s1_hit[i] = 1'b1;
                        w_s1_cdb[i] = w_cdb_data[b];
                    end
                    if (s2_tag_q[i] == w_cdb_tag[b]) begin
                        w_s2_hit[i] = 1'b1;
                        w_s2_cdb[i] = w_cdb_data[b];
                    end
                end
                if (iq_if.disp_src1_tag == w_cdb_tag[b]) begin
                    w_d1_hit = 1'b1;
                    w_d1_cdb = w_cdb_data[b];
                end
                if (iq_if.disp_src2_tag == w_cdb_tag[b]) begin
                    w_d2_hit = 1'b1;
                    w_d2_cdb = w_cdb_data[b];
                end
            end
        end
    end

    logic [DEPTH-1:0] w_alloc;
    logic             w_taken;
    always_comb begin
        w_alloc = '0;
        w_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !w_taken) begin
                w_alloc[i] = 1'b1;
                w_taken    = 1'b1;
            end
        end
    end

    logic w_disp_ready, w_legal, w_store;
    assign w_disp_ready = (occ_q < C_DEPTH);
    assign w_legal      = (iq_if.disp_op != '0) && ({1'b0, iq_if.disp_fu} < C_NUM_FU);
    assign w_store      = iq_if.disp_valid && w_disp_ready && w_legal && w_taken;

    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_older [DEPTH];
    logic [DEPTH-1:0] w_cand  [NUM_FU];
    logic [DEPTH-1:0] w_grant [NUM_FU];
    assign w_elig = valid_q & s1_rdy_q & s2_rdy_q;

    // w_older[i][j] is set when entry j was dispatched before entry i.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_older[i][j] = age_q[j][i];
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            w_cand[f]  = '0;
            w_grant[f] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_cand[f][i] = w_elig[i] && (fu_q[i] == FU_W'(f)) && iq_if.fu_ready[f];
            end
            for (int i = 0; i < DEPTH; i++) begin
                w_grant[f][i] = w_cand[f][i] && ((w_cand[f] & w_older[i]) == '0);
            end
        end
    end

    logic [DEPTH-1:0]  w_issued;
    logic [NUM_FU-1:0] w_fu_go;
    logic [OCC_W-1:0]  w_num_iss;
    logic [31:0]       w_sel_pc   [NUM_FU];
    logic [OP_W-1:0]   w_sel_op   [NUM_FU];
    logic [TAG_W-1:0]  w_sel_dst  [NUM_FU];
    logic [ROB_W-1:0]  w_sel_rob  [NUM_FU];
    logic [DATA_W-1:0] w_sel_imm  [NUM_FU];
    logic [DATA_W-1:0] w_sel_s1   [NUM_FU];
    logic [DATA_W-1:0] w_sel_s2   [NUM_FU];

    always_comb begin
        w_issued  = '0;
        w_fu_go   = '0;
        w_num_iss = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_sel_pc[f]  = '0;
            w_sel_op[f]  = '0;
            w_sel_dst[f] = '0;
            w_sel_rob[f] = '0;
            w_sel_imm[f] = '0;
            w_sel_s1[f]  = '0;
            w_sel_s2[f]  = '0;
            w_fu_go[f]   = |w_grant[f];
            w_issued     = w_issued | w_grant[f];
            w_num_iss    = w_num_iss + OCC_W'(w_fu_go[f]);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant[f][i]) begin
                    w_sel_pc[f]  = pc_q[i];
                    w_sel_op[f]  = op_q[i];
                    w_sel_dst[f] = dst_q[i];
                    w_sel_rob[f] = rob_q[i];
                    w_sel_imm[f] = imm_q[i];
                    w_sel_s1[f]  = s1_data_q[i];
                    w_sel_s2[f]  = s2_data_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            occ_q       <= '0;
            iss_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i]     <= '0;
                fu_q[i]      <= '0;
                pc_q[i]      <= '0;
                op_q[i]      <= '0;
                dst_q[i]     <= '0;
                rob_q[i]     <= '0;
                imm_q[i]     <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
                s1_data_q[i] <= '0;
                s2_data_q[i] <= '0;
            end
            for (int f = 0; f < NUM_FU; f++) begin
                iss_pc_q[f]  <= '0;
                iss_op_q[f]  <= '0;
                iss_dst_q[f] <= '0;
                iss_rob_q[f] <= '0;
                iss_imm_q[f] <= '0;
                iss_s1_q[f]  <= '0;
                iss_s2_q[f]  <= '0;
            end
        end else if (iq_if.flush) begin
            valid_q     <= '0;
            occ_q       <= '0;
            iss_valid_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(w_store) - w_num_iss;
            for (int f = 0; f < NUM_FU; f++) begin
                iss_valid_q[f] <= w_fu_go[f];
                if (w_fu_go[f]) begin
                    iss_pc_q[f]  <= w_sel_pc[f];
                    iss_op_q[f]  <= w_sel_op[f];
                    iss_dst_q[f] <= w_sel_dst[f];
                    iss_rob_q[f] <= w_sel_rob[f];
                    iss_imm_q[f] <= w_sel_imm[f];
                    iss_s1_q[f]  <= w_sel_s1[f];
                    iss_s2_q[f]  <= w_sel_s2[f];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_store && w_alloc[i]) begin
                    // New entry is younger than everyone: empty row, column set below.
                    valid_q[i]   <= 1'b1;
                    age_q[i]     <= '0;
                    fu_q[i]      <= iq_if.disp_fu;
                    pc_q[i]      <= iq_if.disp_pc;
                    op_q[i]      <= iq_if.disp_op;
                    dst_q[i]     <= iq_if.disp_dst;
                    rob_q[i]     <= iq_if.disp_rob;
                    imm_q[i]     <= iq_if.disp_imm;
                    s1_tag_q[i]  <= iq_if.disp_src1_tag;
                    s2_tag_q[i]  <= iq_if.disp_src2_tag;
                    s1_rdy_q[i]  <= iq_if.disp_src1_rdy | w_d1_hit;
                    s2_rdy_q[i]  <= iq_if.disp_src2_rdy | w_d2_hit;
                    s1_data_q[i] <= iq_if.disp_src1_rdy ? iq_if.disp_src1_data : w_d1_cdb;
                    s2_data_q[i] <= iq_if.disp_src2_rdy ? iq_if.disp_src2_data : w_d2_cdb;
                end else begin
                    if (w_issued[i]) begin
                        valid_q[i] <= 1'b0;
                    end
                    if (w_store) begin
                        age_q[i] <= age_q[i] | w_alloc;
                    end
                    if (!s1_rdy_q[i] && w_s1_hit[i]) begin
                        s1_rdy_q[i]  <= 1'b1;
                        s1_data_q[i] <= w_s1_cdb[i];
                    end
                    if (!s2_rdy_q[i] && w_s2_hit[i]) begin
                        s2_rdy_q[i]  <= 1'b1;
                        s2_data_q[i] <= w_s2_cdb[i];
                    end
                end
            end
        end
    end

    assign iq_if.disp_ready = w_disp_ready;
    assign iq_if.occupancy  = occ_q;
    assign iq_if.iss_valid  = iss_valid_q;

    genvar gf;
    generate
        for (gf = 0; gf < NUM_FU; gf++) begin : g_iss
            assign iq_if.iss_pc[gf*32 +: 32]         = iss_pc_q[gf];
            assign iq_if.iss_op[gf*OP_W +: OP_W]     = iss_op_q[gf];
            assign iq_if.iss_dst[gf*TAG_W +: TAG_W]  = iss_dst_q[gf];
            assign iq_if.iss_rob[gf*ROB_W +: ROB_W]  = iss_rob_q[gf];
            assign iq_if.iss_imm[gf*DATA_W +: DATA_W]  = iss_imm_q[gf];
            assign iq_if.iss_src1[gf*DATA_W +: DATA_W] = iss_s1_q[gf];
            assign iq_if.iss_src2[gf*DATA_W +: DATA_W] = iss_s2_q[gf];
        end
    endgenerate

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_full_q;
    logic [32:0] w_perf_sum;
    assign w_perf_sum = {1'b0, perf_issued_q} + 33'(w_num_iss);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issued_q <= '0;
            perf_full_q   <= '0;
        end else if (iq_if.flush) begin
            perf_issued_q <= '0;
            perf_full_q   <= '0;
        end else begin
            perf_issued_q <= w_perf_sum[32] ? '1 : w_perf_sum[31:0];
            if (iq_if.disp_valid && !w_disp_ready && (perf_full_q != '1)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign perf_issued_o      = perf_issued_q;
    assign perf_full_cycles_o = perf_full_q;
`endif
endmodule
`default_nettype wire
